pipeline_controller: RTL

Control and sequencing block for the 5-stage pipelined datapath. It decodes the instruction held in Decode into per-stage control signals and resolves hazards: decode-stage forwarding selects, load-use stalls, and branch resolution with fetch flush. It also runs a halt/single-step state machine that drains the pipeline to a clean architectural boundary for debug. The block sits beside the datapath and connects to its control inputs and hazard-observation outputs.

---
 rtl/pipeline_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// Decode, hazard and run-control sequencing for the 5-stage pipeline.
// Decodes the Decode-stage instruction, resolves forwarding/stall/branch, and drains to HALTED for debug.
module pipeline_controller #(
    parameter int unsigned STALL_CNT_W  = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   eq,
    input  logic [4:0]             rsD,
    input  logic [4:0]             rtD,
    input  logic [4:0]             rdE,
    input  logic [4:0]             rdM,
    input  logic                   regWriteE,
    input  logic                   regWriteM,
    input  logic                   mem2RegE,
    input  logic                   haltReq,
    input  logic                   stepReq,
    output logic                   regWrite,
    output logic                   regDst,
    output logic                   memWrite,
    output logic                   mem2Reg,
    output logic                   aluSrcB,
    output logic [2:0]             aluControl,
    output logic                   pcSrc,
    output logic                   enablePC,
    output logic                   enableD,
    output logic                   flushD,
    output logic                   flushE,
    output logic [1:0]             fad,
    output logic [1:0]             fbd,
    output logic                   halted,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stallCount
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_STEP} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mem2RegM_q, mem2RegM_d;
    logic                   illegal_q, illegal_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic is_beq, use_rs, use_rt, illegal_c, stall;

    // Instruction decode; illegal encodings behave like a NOP for hazards.
    always_comb begin
        regWrite   = 1'b0;
        regDst     = 1'b0;
        memWrite   = 1'b0;
        mem2Reg    = 1'b0;
        aluSrcB    = 1'b0;
        aluControl = 3'b000;
        is_beq     = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        illegal_c  = 1'b0;
        case (opcode)
            6'h00: begin
                if (funct != 6'h00) begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                    use_rs   = 1'b1;
                    use_rt   = 1'b1;
                    case (funct)
                        6'h20:   aluControl = 3'b010;
                        6'h22:   aluControl = 3'b110;
                        6'h24:   aluControl = 3'b000;
                        6'h25:   aluControl = 3'b001;
                        6'h2A:   aluControl = 3'b111;
                        default: begin
                            regWrite  = 1'b0;
                            regDst    = 1'b0;
                            use_rs    = 1'b0;
                            use_rt    = 1'b0;
                            illegal_c = 1'b1;
                        end
                    endcase
                end
            end
            6'h23: begin
                regWrite   = 1'b1;
                mem2Reg    = 1'b1;
                aluSrcB    = 1'b1;
                aluControl = 3'b010;
                use_rs     = 1'b1;
            end
            6'h2B: begin
                memWrite   = 1'b1;
                aluSrcB    = 1'b1;
                aluControl = 3'b010;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
            end
            6'h04: begin
                is_beq = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'h08: begin
                regWrite   = 1'b1;
                aluSrcB    = 1'b1;
                aluControl = 3'b010;
                use_rs     = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Decode-stage forwarding; Execute wins over Memory, loads in Execute are not forwardable.
    always_comb begin
        fad = 2'd0;
        fbd = 2'd0;
        if (use_rs && rsD != 5'd0) begin
            if (rsD == rdE && regWriteE && !mem2RegE) fad = 2'd1;
            else if (rsD == rdM && regWriteM)         fad = mem2RegM_q ? 2'd2 : 2'd3;
        end
        if (use_rt && rtD != 5'd0) begin
            if (rtD == rdE && regWriteE && !mem2RegE) fbd = 2'd1;
            else if (rtD == rdM && regWriteM)         fbd = mem2RegM_q ? 2'd2 : 2'd3;
        end
    end

    assign stall = mem2RegE && regWriteE && (rdE != 5'd0) &&
                   ((use_rs && rsD == rdE) || (use_rt && rtD == rdE));
    assign pcSrc = is_beq && eq && !stall;

    // Run-control FSM and pipeline enables; cnt_q == 0 means the drain count has not started.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enablePC = stall;
        enableD  = stall;
        flushE   = stall;
        flushD   = pcSrc;
        halted   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (haltReq) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_STEP: begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                if (!stall) begin
                    flushD   = 1'b1;
                    enableD  = 1'b0;
                    enablePC = !pcSrc;
                end
                if (cnt_q == '0) begin
                    if (!stall) cnt_d = CNT_W'(1);
                end else if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
                    state_d = S_HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALTED: begin
                halted   = 1'b1;
                enablePC = 1'b1;
                flushD   = 1'b1;
                if (!haltReq)     state_d = S_RUN;
                else if (stepReq) state_d = S_STEP;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign mem2RegM_d  = mem2RegE;
    assign illegal_d   = illegal_q | illegal_c;
    assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            mem2RegM_q  <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem2RegM_q  <= mem2RegM_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign illegal    = illegal_q;
    assign stallCount = stall_cnt_q;

endmodule
